// File: rtl/alu_issue_sequencer_if.sv
// Request, ALU-side and response signals of the ALU issue sequencer.
// Latency: none; this is a plain signal bundle.
// Backpressure: req_ready toward the requester, rsp_ready from the consumer.
// Ports (slave = sequencer side):
//   req_valid/req_ready/req_op/req_a/req_b     request handshake
//   alu_op_code/alu_a/alu_b/alu_result         held ALU operands, combinational result
//   rsp_valid/rsp_ready/rsp_result/rsp_op      response handshake
//   busy                                       work queued or in flight
interface alu_issue_sequencer_if #(
  parameter int W = 8
);
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [1:0]   alu_op_code;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_result;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic [1:0]   rsp_op;
  logic         busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_result, rsp_ready,
    output req_ready, alu_op_code, alu_a, alu_b, rsp_valid, rsp_result, rsp_op, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b, alu_result, rsp_ready,
    input  req_ready, alu_op_code, alu_a, alu_b, rsp_valid, rsp_result, rsp_op, busy
  );
endinterface

// File: rtl/alu_issue_sequencer.sv
// Queues ALU requests, issues them one at a time to a shared ALU, returns results.
// Latency: request accepted at edge N into an idle block -> rsp_valid after edge N+2.
// Backpressure: rsp_ready low holds the response; FIFO fills, then req_ready drops.
// Ports:
//   clk, rst   single clock, synchronous active-high reset
//   bus        alu_issue_sequencer_if.slave (request, ALU and response signals)
module alu_issue_sequencer #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  alu_issue_sequencer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } req_t;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  req_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  state_t        state_q;
  logic [1:0]    alu_op_q;
  logic [W-1:0]  alu_a_q, alu_b_q;
  logic          rsp_valid_q;
  logic [W-1:0]  rsp_result_q;
  logic [1:0]    rsp_op_q;

  logic req_ready_w;
  logic push, pop, fifo_nempty;
  req_t head;

  // Full check deliberately ignores a same-cycle pop so req_ready is purely registered state.
  assign req_ready_w = (count_q != FULL);
  assign push        = bus.req_valid && req_ready_w;
  assign fifo_nempty = (count_q != '0);
  assign pop         = fifo_nempty &&
                       ((state_q == IDLE) || (state_q == RESP && bus.rsp_ready));
  assign head        = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= '{op: bus.req_op, a: bus.req_a, b: bus.req_b};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Issue FSM; ALU hold registers only move on a pop so the ALU inputs never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_op_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            alu_op_q <= head.op;
            alu_a_q  <= head.a;
            alu_b_q  <= head.b;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q <= bus.alu_result;
          rsp_op_q     <= alu_op_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (pop) begin
              alu_op_q <= head.op;
              alu_a_q  <= head.a;
              alu_b_q  <= head.b;
              state_q  <= EXEC;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = req_ready_w;
  assign bus.alu_op_code = alu_op_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_op      = rsp_op_q;
  assign bus.busy        = (state_q != IDLE) || fifo_nempty;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Bench for alu_issue_sequencer with a behavioural ALU and a response scoreboard.
// Latency/backpressure exercised: single op, streaming, full FIFO, reset mid-op.
// Expected {op,result} pairs are queued on acceptance and compared on each response.
module tb_alu_issue_sequencer;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  logic [9:0] exp_q [$];
  int         hs_q  [$];

  alu_issue_sequencer_if #(.W(8)) bus_if ();

  alu_issue_sequencer #(.W(8), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  function automatic logic [7:0] alu_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   alu_fn = a + b;
      2'b01:   alu_fn = a - b;
      2'b10:   alu_fn = a & b;
      default: alu_fn = a | b;
    endcase
  endfunction

  assign bus_if.alu_result = alu_fn(bus_if.alu_op_code, bus_if.alu_a, bus_if.alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response monitor: every valid cycle must match the scoreboard head (also proves stability).
  always @(negedge clk) begin
    if (!rst && bus_if.rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("stale_rsp_qsize", exp_q.size(), 1);
      end else begin
        check("rsp_result", bus_if.rsp_result, exp_q[0][7:0]);
        check("rsp_op", bus_if.rsp_op, exp_q[0][9:8]);
        if (bus_if.rsp_ready) begin
          void'(exp_q.pop_front());
          hs_q.push_back(cyc);
        end
      end
    end
  end

  // Call at posedge+#1; returns at posedge+#1.
  task automatic try_send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int limit, output bit acc);
    bus_if.req_valid = 1'b1;
    bus_if.req_op    = op;
    bus_if.req_a     = a;
    bus_if.req_b     = b;
    acc = 1'b0;
    for (int i = 0; i < limit && !acc; i++) begin
      @(negedge clk);
      if (bus_if.req_ready) begin
        exp_q.push_back({op, alu_fn(op, a, b)});
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus_if.req_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    bit acc;
    try_send(op, a, b, 50, acc);
    check("send_accept", acc, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && (exp_q.size() != 0 || bus_if.rsp_valid); i++) @(negedge clk);
    check("drain_qsize", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int n_acc;

    // T1: reset held two cycles with a request offered
    rst = 1'b1;
    bus_if.req_valid = 1'b1;
    bus_if.req_op    = 2'b01;
    bus_if.req_a     = 8'h55;
    bus_if.req_b     = 8'h11;
    bus_if.rsp_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("t1_rsp_valid", bus_if.rsp_valid, 0);
    check("t1_req_ready", bus_if.req_ready, 1);
    check("t1_busy", bus_if.busy, 0);
    check("t1_alu_op", bus_if.alu_op_code, 0);
    check("t1_alu_a", bus_if.alu_a, 0);
    check("t1_alu_b", bus_if.alu_b, 0);
    check("t1_rsp_result", bus_if.rsp_result, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus_if.req_valid = 1'b0;
    @(negedge clk);
    check("t1_no_push_busy", bus_if.busy, 0);
    @(posedge clk);
    #1;

    // T2: single ADD, latency
    bus_if.rsp_ready = 1'b1;
    send(2'b00, 8'h7F, 8'h01);
    @(negedge clk);
    check("t2_valid_n0", bus_if.rsp_valid, 0);
    @(negedge clk);
    check("t2_valid_n1", bus_if.rsp_valid, 0);
    @(negedge clk);
    check("t2_valid_n2", bus_if.rsp_valid, 1);
    @(negedge clk);
    check("t2_valid_n3", bus_if.rsp_valid, 0);
    check("t2_idle_busy", bus_if.busy, 0);
    @(posedge clk);
    #1;

    // T3: streaming, one response every 2 cycles
    hs_q.delete();
    send(2'b01, 8'h00, 8'h01);
    send(2'b10, 8'hF0, 8'h3C);
    send(2'b11, 8'hF0, 8'h0F);
    send(2'b00, 8'hFF, 8'h02);
    wait_drain();
    check("t3_hs_count", hs_q.size(), 4);
    if (hs_q.size() == 4) begin
      for (int i = 0; i < 3; i++) check("t3_gap", hs_q[i+1] - hs_q[i], 2);
    end

    // T4/T6: backpressure, 6 offered, 5 accepted, then release against full FIFO
    bus_if.rsp_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      try_send(2'(i), 8'(8'h10 * i + 3), 8'(i + 1), 3, acc);
      if (acc) n_acc++;
    end
    check("t4_accepted", n_acc, 5);
    @(negedge clk);
    check("t4_ready_full", bus_if.req_ready, 0);
    check("t4_busy", bus_if.busy, 1);
    @(posedge clk);
    #1;
    bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    check("t6_ready_at_pop", bus_if.req_ready, 0);
    @(negedge clk);
    check("t6_ready_after_pop", bus_if.req_ready, 1);
    @(posedge clk);
    #1;
    wait_drain();

    // T5: reset while in RESP with 3 queued
    bus_if.rsp_ready = 1'b0;
    send(2'b00, 8'h01, 8'h02);
    send(2'b01, 8'h09, 8'h03);
    send(2'b10, 8'hAA, 8'h0F);
    send(2'b11, 8'h30, 8'h03);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t5_rsp_valid", bus_if.rsp_valid, 0);
    check("t5_busy", bus_if.busy, 0);
    check("t5_req_ready", bus_if.req_ready, 1);
    check("t5_alu_a", bus_if.alu_a, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus_if.rsp_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_no_stale_valid", bus_if.rsp_valid, 0);
    check("t5_no_stale_busy", bus_if.busy, 0);
    @(posedge clk);
    #1;

    // Post-reset sanity: block still works
    send(2'b01, 8'h05, 8'h07);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
